// File: rtl/tick_timer_multi_pkg.sv
// Shared definitions for the multi-channel tick timer.
// Period constants are expressed in cycles of the 12 MHz system clock.
// Contents: period constants, mode encodings, channel FSM state type.
package tick_timer_multi_pkg;

  localparam int unsigned T_1US   = 32'd12;
  localparam int unsigned T_1MS   = 32'd12_000;
  localparam int unsigned T_10MS  = 32'd120_000;
  localparam int unsigned T_100MS = 32'd1_200_000;
  localparam int unsigned T_1S    = 32'd12_000_000;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage : tick_timer_multi_pkg

// File: rtl/tick_timer_multi_tick_channel.sv
// One timer channel: FSM, counter, shadow/active period with pending
// transfer, registered tick, busy and sticky done.
// Ports:
//   clk, rstn          clock, async active-low reset
//   ena, mode          run enable (level), 0 = periodic / 1 = one-shot
//   wr, wr_val         period write strobe and value
//   clr_done           clear of the sticky done flag
//   tick, busy, done   registered outputs
module tick_channel
  import tick_timer_multi_pkg::*;
#(
  parameter int unsigned W              = 24,
  parameter int unsigned DEFAULT_PERIOD = T_100MS
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ena,
  input  logic         mode,
  input  logic         wr,
  input  logic [W-1:0] wr_val,
  input  logic         clr_done,
  output logic         tick,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] ZERO_W  = {W{1'b0}};
  localparam logic [W-1:0] ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] PER_RST = W'(DEFAULT_PERIOD);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] per_act_q, per_act_d;
  logic [W-1:0] per_shadow_q, per_shadow_d;
  logic         pending_q, pending_d;
  logic         mode_q, mode_d;
  logic         tick_q, tick_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // A programmed period of 0 behaves exactly like a period of 1.
  function automatic logic [W-1:0] eff_period(input logic [W-1:0] per);
    if (per == ZERO_W) begin
      eff_period = ONE_W;
    end else begin
      eff_period = per;
    end
  endfunction

  logic         step_s;
  logic         step_mode_s;
  logic         last_s;

  // Next-state logic: FSM, counter, period transfer, load and done.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    per_act_d    = per_act_q;
    per_shadow_d = per_shadow_q;
    pending_d    = pending_q;
    mode_d       = mode_q;
    tick_d       = 1'b0;
    step_s       = 1'b0;
    step_mode_s  = mode_q;
    last_s       = (cnt_q == (eff_period(per_act_q) - ONE_W));

    // The edge that moves IDLE->RUN already counts as the first cycle of
    // the period, so a tick follows the P-th edge with ena sampled high.
    case (state_q)
      ST_IDLE: begin
        cnt_d = ZERO_W;
        if (ena) begin
          state_d     = ST_RUN;
          mode_d      = mode;
          step_s      = 1'b1;
          step_mode_s = mode;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!ena) begin
          state_d = ST_IDLE;
          cnt_d   = ZERO_W;
        end else begin
          step_s = 1'b1;
        end
      end
      ST_HOLD: begin
        cnt_d = ZERO_W;
        if (!ena) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO_W;
      end
    endcase

    if (step_s) begin
      if (last_s) begin
        cnt_d  = ZERO_W;
        tick_d = 1'b1;
        if (pending_q) begin
          per_act_d = per_shadow_q;
          pending_d = 1'b0;
        end else begin
          per_act_d = per_act_q;
        end
        if (step_mode_s == MODE_ONESHOT) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        cnt_d = cnt_q + ONE_W;
      end
    end else begin
      tick_d = 1'b0;
    end

    // Applied after the wrap so a load coinciding with a wrap stays
    // pending: the wrap above took the old shadow value.
    if (wr) begin
      per_shadow_d = wr_val;
      if (state_q == ST_RUN) begin
        pending_d = 1'b1;
      end else begin
        per_act_d = wr_val;
        pending_d = 1'b0;
      end
    end else begin
      per_shadow_d = per_shadow_d;
    end

    busy_d = (state_d == ST_RUN);

    // Set has priority over clear.
    if (tick_d) begin
      done_d = 1'b1;
    end else if (clr_done) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= ZERO_W;
      per_act_q    <= PER_RST;
      per_shadow_q <= PER_RST;
      pending_q    <= 1'b0;
      mode_q       <= MODE_PERIODIC;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      per_act_q    <= per_act_d;
      per_shadow_q <= per_shadow_d;
      pending_q    <= pending_d;
      mode_q       <= mode_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign tick = tick_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : tick_channel

// File: rtl/tick_timer_multi.sv
// Multi-channel programmable tick generator.
// Ports:
//   clk, rstn              12 MHz clock, async active-low reset
//   ena[NCH], mode[NCH]    per-channel run enable and mode (0 periodic, 1 one-shot)
//   load, load_ch, load_val  1-cycle period write to channel load_ch
//   clr_done[NCH]          per-channel clear of the sticky done flag
//   tick/busy/done[NCH]    registered per-channel outputs
module tick_timer_multi
  import tick_timer_multi_pkg::*;
#(
  parameter int unsigned NCH            = 4,
  parameter int unsigned W              = 24,
  parameter int unsigned DEFAULT_PERIOD = T_100MS,
  localparam int unsigned CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] ena,
  input  logic [NCH-1:0] mode,
  input  logic           load,
  input  logic [CHW-1:0] load_ch,
  input  logic [W-1:0]   load_val,
  input  logic [NCH-1:0] clr_done,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done
);

  logic [NCH-1:0] wr_onehot;

  // Load decode; an index >= NCH matches no channel and is dropped.
  always_comb begin
    wr_onehot = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (load && (load_ch == CHW'(i))) begin
        wr_onehot[i] = 1'b1;
      end else begin
        wr_onehot[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_channel #(
      .W              (W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .ena      (ena[g]),
      .mode     (mode[g]),
      .wr       (wr_onehot[g]),
      .wr_val   (load_val),
      .clr_done (clr_done[g]),
      .tick     (tick[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

endmodule : tick_timer_multi

// File: doc/tick_timer_multi.md
Name: tick_timer_multi

Overview:
Multi-channel programmable tick generator, the parametrised successor of the single-channel fixed-period divider.
- NCH independent channels, each with a runtime-loadable period, a periodic or one-shot mode, a registered 1-cycle tick and a sticky done flag.
- Sits between the 12 MHz system clock and timing consumers: LED blink, delay states in controllers, baud and sample strobes.
- Replaces multiple fixed-M divider instances with one block.

Parameters:
- NCH, 4, number of channels (1..16).
- W, 24, counter and period width in bits.
- DEFAULT_PERIOD, `T_100ms, reset value of every channel's period, in clk cycles; must fit in W bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- ena  in  NCH  per-channel run enable, level-sensitive.
- mode  in  NCH  per-channel mode: 0 = periodic, 1 = one-shot.
- load  in  1  1-cycle strobe that writes load_val into the shadow period of channel load_ch.
- load_ch  in  $clog2(NCH) (min 1)  channel index for load.
- load_val  in  W  new period in cycles.
- clr_done  in  NCH  per-channel clear of the done flag.
- tick  out  NCH  registered pulse, exactly 1 clk cycle wide.
- busy  out  NCH  high while the channel is in RUN.
- done  out  NCH  sticky flag, set on every tick of the channel.

Behaviour:
- Reset (rstn=0, asynchronous), per channel:
  - cnt=0, state=IDLE.
  - per_act = per_shadow = DEFAULT_PERIOD; pending=0.
  - tick=0, busy=0, done=0.
- Period rule: a period value of 0 is treated as 1. A period of 1 gives a tick on every cycle while running.
- Per-channel FSM:
  - IDLE: cnt held at 0. If ena=1, go to RUN and latch mode into mode_q. Mode changes during RUN are ignored.
  - RUN: if ena=0, go to IDLE with cnt<=0 (abort; no tick, pending load is kept). Otherwise:
    - If cnt == per_act-1: cnt<=0 and tick<=1 for the next cycle.
    - Also at that point, if pending, per_act<=per_shadow and pending<=0.
    - Then, if mode_q=1, go to HOLD.
    - Otherwise cnt<=cnt+1.
  - HOLD (one-shot finished): cnt held at 0, busy=0. Go to IDLE only when ena is sampled 0. Re-arming requires ena low for at least 1 cycle.
- Latency: the first tick is high during the cycle following the P-th rising edge at which ena is sampled 1 (P = effective period). Periodic ticks are then spaced exactly P cycles apart.
- busy is registered: busy=1 exactly when state==RUN.
- Load:
  - On a load cycle, per_shadow[load_ch]<=load_val.
  - If the channel is in IDLE or HOLD, per_act is also updated immediately and pending stays 0.
  - If the channel is in RUN, pending<=1 and the new period applies from the next wrap. The current period is never truncated.
  - A load_ch >= NCH is ignored.
  - Repeated loads before the wrap: the last one wins.
- Load on the same cycle as a wrap of that channel: the wrap transfers the old shadow, and the new value stays pending for the following wrap.
- done[i]:
  - Set in the cycle tick[i] rises; cleared by clr_done[i].
  - If set and clear happen on the same cycle, set wins.
  - Not cleared by ena.
- Channels are fully independent; simultaneous ticks on all channels are legal.
- Counter arithmetic is unsigned W-bit; cnt never exceeds per_act-1, so no overflow is possible.

Decomposition:
- Shared header divider.vh: the T_xxx period constants, plus MODE_PERIODIC=0 and MODE_ONESHOT=1, and the state encodings IDLE=2'd0, RUN=2'd1, HOLD=2'd2.
- One sub-module, tick_channel: holds the FSM, counter, shadow/active period, pending, tick, busy and done for one channel. Ports: clk, rstn, ena, mode, wr, wr_val, clr_done, tick, busy, done.
- The top decodes load/load_ch into a one-hot wr and instantiates NCH copies with a generate loop.

Test Plan:
1. Reset and default period. Release rstn with DEFAULT_PERIOD=10, raise ena[0] with mode=0.
   Required: tick[0] high 1 cycle after the 10th sampled edge, then every 10 cycles; busy[0]=1; other channels silent.
2. One-shot. Load period 5 into ch1 while idle, then ena[1]=1 with mode=1.
   Required: a single tick after 5 edges; busy drops to 0; no further ticks while ena stays 1. Drop ena for 1 cycle and raise it again: another single tick after 5 edges.
3. Load during RUN. Ch0 running with P=8; at cnt=3, load 3.
   Required: the current period completes at 8 cycles, then ticks every 3 cycles. A load_ch=NCH strobe changes nothing.
4. Boundary periods. Load 0 and 1 into ch2 in turn and enable it.
   Required: tick[2] stays high continuously, i.e. a tick every cycle, in both cases.
5. Abort and reset mid-operation.
   - Ch3 with P=6: drop ena at cnt=4. Required: no tick; re-enabling gives the first tick after 6 edges.
   - Assert rstn=0 mid-run. Required: tick, busy and done go to 0 immediately, asynchronously.
6. done flag. Let a tick set done[0].
   - Assert clr_done[0] on the same cycle as the next tick. Required: done[0] stays 1.
   - Assert clr_done[0] alone. Required: done[0] goes to 0.
